// File: rtl/core_mem_arbiter_pkg.sv
// Shared types and constants for the core memory-port arbiter.
package core_mem_arbiter_pkg;

  // Arbiter FSM states.
  typedef enum logic [1:0] {
    StIdle = 2'b00,
    StReq  = 2'b01,
    StWait = 2'b10
  } arb_state_e;

  // Owner codes; also the select value for the request-side muxes.
  localparam logic OwnIf = 1'b0;
  localparam logic OwnLs = 1'b1;

  // Winner of an IDLE-cycle arbitration.
  // rr_en selects the tie-break: when set, the port that was not last_owner wins;
  // when clear, LS wins.
  function automatic logic arb_pick(input logic if_req, input logic ls_req,
                                    input logic rr_en, input logic last_owner);
    logic win;
    if (if_req && ls_req) begin
      win = rr_en ? ~last_owner : OwnLs;
    end else begin
      win = ls_req ? OwnLs : OwnIf;
    end
    return win;
  endfunction

endpackage

// File: rtl/core_mem_arbiter_mux2.sv
// Generic 2:1 multiplexer used to steer requester fields onto the memory port.
module core_mem_arbiter_mux2 #(
  parameter int unsigned Width = 32
) (
  input  logic [Width-1:0] in0_i,
  input  logic [Width-1:0] in1_i,
  input  logic             sel_i,
  output logic [Width-1:0] out_o
);

  // sel_i = 1 picks in1_i.
  always_comb begin
    out_o = sel_i ? in1_i : in0_i;
  end

endmodule

// File: rtl/core_mem_arbiter.sv
// Arbiter sharing the core's single memory port between instruction fetch (IF)
// and the load/store unit (LS). One transaction is outstanding at a time:
// request, grant, then response, routed back to the owner only.
// Optional macro ARB_ROUND_ROBIN_EN: tie-break alternates between ports using a
// last-owner flop; when undefined, LS has fixed priority over IF.
module core_mem_arbiter
  import core_mem_arbiter_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  // Instruction fetch port
  input  logic                    if_req_i,
  input  logic [ADDR_WIDTH-1:0]   if_addr_i,
  output logic                    if_gnt_o,
  output logic                    if_rvalid_o,
  output logic [DATA_WIDTH-1:0]   if_rdata_o,
  // Load/store port
  input  logic                    ls_req_i,
  input  logic                    ls_we_i,
  input  logic [DATA_WIDTH/8-1:0] ls_be_i,
  input  logic [ADDR_WIDTH-1:0]   ls_addr_i,
  input  logic [DATA_WIDTH-1:0]   ls_wdata_i,
  output logic                    ls_gnt_o,
  output logic                    ls_rvalid_o,
  output logic [DATA_WIDTH-1:0]   ls_rdata_o,
  // Memory port
  output logic                    mem_req_o,
  output logic                    mem_we_o,
  output logic [DATA_WIDTH/8-1:0] mem_be_o,
  output logic [ADDR_WIDTH-1:0]   mem_addr_o,
  output logic [DATA_WIDTH-1:0]   mem_wdata_o,
  input  logic                    mem_gnt_i,
  input  logic                    mem_rvalid_i,
  input  logic [DATA_WIDTH-1:0]   mem_rdata_i,
  // Current owner
  output logic                    sel_o
);

  arb_state_e state_q;
  logic       owner_q;
  logic       winner;
  logic       gnt_fire;
  logic       rvalid_fire;

`ifdef ARB_ROUND_ROBIN_EN
  logic last_owner_q;

  // Remember who was granted most recently so ties go to the other port.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      last_owner_q <= OwnIf;
    end else if (gnt_fire) begin
      last_owner_q <= owner_q;
    end
  end

  // Winner of the IDLE-cycle arbitration.
  always_comb begin
    winner = arb_pick(if_req_i, ls_req_i, 1'b1, last_owner_q);
  end
`else
  // Winner of the IDLE-cycle arbitration.
  always_comb begin
    winner = arb_pick(if_req_i, ls_req_i, 1'b0, OwnIf);
  end
`endif

  // Transaction sequencer; owner is latched only in IDLE and held until the next arbitration.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= StIdle;
      owner_q <= OwnIf;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (if_req_i || ls_req_i) begin
            owner_q <= winner;
            state_q <= StReq;
          end
        end
        StReq: begin
          if (mem_gnt_i) begin
            state_q <= StWait;
          end
        end
        StWait: begin
          if (mem_rvalid_i) begin
            state_q <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  // Handshake events; forced low during reset so an in-flight response is dropped.
  always_comb begin
    gnt_fire    = ~rst_i && (state_q == StReq) && mem_gnt_i;
    rvalid_fire = ~rst_i && (state_q == StWait) && mem_rvalid_i;
  end

  // Route grant and response to the owner only; rdata is zero outside a response.
  always_comb begin
    sel_o       = owner_q;
    mem_req_o   = ~rst_i && (state_q == StReq);
    if_gnt_o    = gnt_fire && (owner_q == OwnIf);
    ls_gnt_o    = gnt_fire && (owner_q == OwnLs);
    if_rvalid_o = rvalid_fire && (owner_q == OwnIf);
    ls_rvalid_o = rvalid_fire && (owner_q == OwnLs);
    if_rdata_o  = if_rvalid_o ? mem_rdata_i : '0;
    ls_rdata_o  = ls_rvalid_o ? mem_rdata_i : '0;
  end

  // IF never writes: read of the full word.
  always_comb begin
    mem_we_o = (owner_q == OwnLs) && ls_we_i;
    mem_be_o = (owner_q == OwnLs) ? ls_be_i : '1;
  end

  core_mem_arbiter_mux2 #(
    .Width (ADDR_WIDTH)
  ) u_addr_mux (
    .in0_i (if_addr_i),
    .in1_i (ls_addr_i),
    .sel_i (owner_q),
    .out_o (mem_addr_o)
  );

  core_mem_arbiter_mux2 #(
    .Width (DATA_WIDTH)
  ) u_wdata_mux (
    .in0_i ('0),
    .in1_i (ls_wdata_i),
    .sel_i (owner_q),
    .out_o (mem_wdata_o)
  );

endmodule

// File: tb/tb_core_mem_arbiter.sv
// Self-checking bench for core_mem_arbiter: directed vector table, a continuous
// contention sequence, and randomized traffic against a transaction-level model.
module tb_core_mem_arbiter;
  localparam int unsigned AW = 32;
  localparam int unsigned DW = 32;
  localparam int unsigned BW = DW / 8;

  logic          clk = 1'b0;
  logic          rst;
  logic          if_req, if_gnt, if_rvalid;
  logic [AW-1:0] if_addr;
  logic [DW-1:0] if_rdata;
  logic          ls_req, ls_we, ls_gnt, ls_rvalid;
  logic [BW-1:0] ls_be;
  logic [AW-1:0] ls_addr;
  logic [DW-1:0] ls_wdata, ls_rdata;
  logic          mem_req, mem_we, mem_gnt, mem_rvalid, sel;
  logic [BW-1:0] mem_be;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata, mem_rdata;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  core_mem_arbiter #(
    .ADDR_WIDTH (AW),
    .DATA_WIDTH (DW)
  ) dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .if_req_i     (if_req),
    .if_addr_i    (if_addr),
    .if_gnt_o     (if_gnt),
    .if_rvalid_o  (if_rvalid),
    .if_rdata_o   (if_rdata),
    .ls_req_i     (ls_req),
    .ls_we_i      (ls_we),
    .ls_be_i      (ls_be),
    .ls_addr_i    (ls_addr),
    .ls_wdata_i   (ls_wdata),
    .ls_gnt_o     (ls_gnt),
    .ls_rvalid_o  (ls_rvalid),
    .ls_rdata_o   (ls_rdata),
    .mem_req_o    (mem_req),
    .mem_we_o     (mem_we),
    .mem_be_o     (mem_be),
    .mem_addr_o   (mem_addr),
    .mem_wdata_o  (mem_wdata),
    .mem_gnt_i    (mem_gnt),
    .mem_rvalid_i (mem_rvalid),
    .mem_rdata_i  (mem_rdata),
    .sel_o        (sel)
  );

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s @%0t: got %0h expected %0h", nm, $time, act, exp);
    end
  endtask

  // Memory-side fields must follow the expected owner while a request is out.
  task automatic chk_mem_fields(input string tag, input logic exp_sel);
    if (exp_sel) begin
      chk({tag, " mem_addr"}, 64'(mem_addr), 64'(ls_addr));
      chk({tag, " mem_we"}, 64'(mem_we), 64'(ls_we));
      chk({tag, " mem_be"}, 64'(mem_be), 64'(ls_be));
      chk({tag, " mem_wdata"}, 64'(mem_wdata), 64'(ls_wdata));
    end else begin
      chk({tag, " mem_addr"}, 64'(mem_addr), 64'(if_addr));
      chk({tag, " mem_we"}, 64'(mem_we), 64'd0);
      chk({tag, " mem_be"}, 64'(mem_be), 64'hF);
      chk({tag, " mem_wdata"}, 64'(mem_wdata), 64'd0);
    end
  endtask

  // ---------------- transaction-level reference model ----------------
  typedef struct packed {
    logic own;      // 1 = LS
    logic granted;
  } txn_t;

  txn_t q[$];
  logic m_sel  = 1'b0;
  logic m_last = 1'b0;
  logic e_mreq, e_ifg, e_lsg, e_ifr, e_lsr;

  function automatic logic model_pick(input logic ir, input logic lr, input logic last);
`ifdef ARB_ROUND_ROBIN_EN
    if (ir && lr) return ~last;
`else
    if (ir && lr) return 1'b1;
`endif
    return lr;
  endfunction

  task automatic model_eval();
    e_mreq = 0; e_ifg = 0; e_lsg = 0; e_ifr = 0; e_lsr = 0;
    if (!rst && q.size() > 0) begin
      if (!q[0].granted) begin
        e_mreq = 1;
        if (mem_gnt) begin
          if (q[0].own) e_lsg = 1; else e_ifg = 1;
        end
      end else if (mem_rvalid) begin
        if (q[0].own) e_lsr = 1; else e_ifr = 1;
      end
    end
  endtask

  task automatic model_step();
    txn_t t;
    if (rst) begin
      q.delete();
      m_sel  = 1'b0;
      m_last = 1'b0;
    end else if (q.size() == 0) begin
      if (if_req || ls_req) begin
        t.own     = model_pick(if_req, ls_req, m_last);
        t.granted = 1'b0;
        q.push_back(t);
        m_sel = t.own;
      end
    end else if (!q[0].granted) begin
      if (mem_gnt) begin
        t = q[0];
        t.granted = 1'b1;
        q[0] = t;
        m_last = t.own;
      end
    end else if (mem_rvalid) begin
      void'(q.pop_front());
    end
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    logic rst, ir, lr, g, rv;
    logic mreq, sel, ifg, lsg, ifr, lsr;
  } vec_t;

  function automatic vec_t mk(input logic r, input logic ir, input logic lr, input logic g,
                              input logic rv, input logic mreq, input logic s, input logic ifg,
                              input logic lsg, input logic ifr, input logic lsr);
    vec_t v;
    v.rst = r; v.ir = ir; v.lr = lr; v.g = g; v.rv = rv;
    v.mreq = mreq; v.sel = s; v.ifg = ifg; v.lsg = lsg; v.ifr = ifr; v.lsr = lsr;
    return v;
  endfunction

  localparam logic [DW-1:0] RDATA_K = 32'h0013_0093;
  vec_t tbl[21];
  logic gq[$];
  logic exp_seq[4];
  logic ig, lg;

  initial begin
    //           rst ir lr g rv | mreq sel ifg lsg ifr lsr
    tbl[0]  = mk(1, 1, 0, 0, 0,  0, 0, 0, 0, 0, 0);  // reset held with if_req
    tbl[1]  = mk(1, 1, 0, 1, 1,  0, 0, 0, 0, 0, 0);
    tbl[2]  = mk(0, 1, 0, 0, 0,  0, 0, 0, 0, 0, 0);  // IDLE arbitrates IF
    tbl[3]  = mk(0, 1, 0, 1, 0,  1, 0, 1, 0, 0, 0);  // immediate grant
    tbl[4]  = mk(0, 0, 0, 0, 1,  0, 0, 0, 0, 1, 0);  // IF response
    tbl[5]  = mk(0, 1, 1, 0, 0,  0, 0, 0, 0, 0, 0);  // tie: LS wins
    tbl[6]  = mk(0, 1, 1, 0, 0,  1, 1, 0, 0, 0, 0);
    tbl[7]  = mk(0, 1, 1, 1, 0,  1, 1, 0, 1, 0, 0);
    tbl[8]  = mk(0, 1, 0, 0, 0,  0, 1, 0, 0, 0, 0);
    tbl[9]  = mk(0, 1, 0, 0, 1,  0, 1, 0, 0, 0, 1);  // LS ack
    tbl[10] = mk(0, 1, 0, 0, 0,  0, 1, 0, 0, 0, 0);  // IF arbitrated
    tbl[11] = mk(0, 1, 1, 0, 0,  1, 0, 0, 0, 0, 0);  // stall 5 cycles, LS toggles
    tbl[12] = mk(0, 1, 0, 0, 1,  1, 0, 0, 0, 0, 0);  // rvalid in REQ ignored
    tbl[13] = mk(0, 1, 1, 0, 0,  1, 0, 0, 0, 0, 0);
    tbl[14] = mk(0, 1, 0, 0, 0,  1, 0, 0, 0, 0, 0);
    tbl[15] = mk(0, 1, 1, 0, 0,  1, 0, 0, 0, 0, 0);
    tbl[16] = mk(0, 1, 0, 1, 0,  1, 0, 1, 0, 0, 0);
    tbl[17] = mk(0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0);  // in WAIT
    tbl[18] = mk(1, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0);  // reset in WAIT
    tbl[19] = mk(0, 0, 0, 0, 1,  0, 0, 0, 0, 0, 0);  // late rvalid ignored
    tbl[20] = mk(0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0);

    rst = 1; if_req = 0; ls_req = 0; mem_gnt = 0; mem_rvalid = 0;
    if_addr = 32'h0000_0040; ls_addr = 32'h0000_0100; ls_we = 1;
    ls_wdata = 32'hDEAD_BEEF; ls_be = 4'b0011; mem_rdata = RDATA_K;
    @(posedge clk); #1;

    for (int i = 0; i < 21; i++) begin
      rst = tbl[i].rst; if_req = tbl[i].ir; ls_req = tbl[i].lr;
      mem_gnt = tbl[i].g; mem_rvalid = tbl[i].rv;
      #4;
      chk($sformatf("v%0d mem_req", i), 64'(mem_req), 64'(tbl[i].mreq));
      chk($sformatf("v%0d sel", i), 64'(sel), 64'(tbl[i].sel));
      chk($sformatf("v%0d if_gnt", i), 64'(if_gnt), 64'(tbl[i].ifg));
      chk($sformatf("v%0d ls_gnt", i), 64'(ls_gnt), 64'(tbl[i].lsg));
      chk($sformatf("v%0d if_rvalid", i), 64'(if_rvalid), 64'(tbl[i].ifr));
      chk($sformatf("v%0d ls_rvalid", i), 64'(ls_rvalid), 64'(tbl[i].lsr));
      chk($sformatf("v%0d if_rdata", i), 64'(if_rdata), tbl[i].ifr ? 64'(RDATA_K) : 64'd0);
      chk($sformatf("v%0d ls_rdata", i), 64'(ls_rdata), tbl[i].lsr ? 64'(RDATA_K) : 64'd0);
      if (tbl[i].mreq) chk_mem_fields($sformatf("v%0d", i), tbl[i].sel);
      @(posedge clk); #1;
    end

    // Both ports requesting continuously with a zero-wait memory.
    rst = 1; if_req = 1; ls_req = 1; mem_gnt = 1; mem_rvalid = 1;
    @(posedge clk); #1;
    rst = 0;
    for (int c = 0; c < 40 && gq.size() < 4; c++) begin
      #4;
      if (ls_gnt) gq.push_back(1'b1);
      if (if_gnt) gq.push_back(1'b0);
      @(posedge clk); #1;
    end
`ifdef ARB_ROUND_ROBIN_EN
    exp_seq = '{1'b1, 1'b0, 1'b1, 1'b0};
`else
    exp_seq = '{1'b1, 1'b1, 1'b1, 1'b1};
`endif
    chk("contention grant count", 64'(gq.size()), 64'd4);
    for (int k = 0; k < 4; k++) begin
      if (k < gq.size()) chk($sformatf("contention grant%0d owner", k), 64'(gq[k]),
                             64'(exp_seq[k]));
    end

    // Randomized traffic against the model.
    ig = 0; lg = 0;
    for (int c = 0; c < 3000; c++) begin
      rst        = (c == 0) || ($urandom_range(0, 299) == 0);
      mem_gnt    = ($urandom_range(0, 2) != 0);
      mem_rvalid = ($urandom_range(0, 2) != 0);
      mem_rdata  = $urandom;
      if (!if_req || ig) begin
        if_req  = ($urandom_range(0, 2) != 0);
        if_addr = $urandom;
      end
      if (!ls_req || lg) begin
        ls_req   = ($urandom_range(0, 2) != 0);
        ls_we    = $urandom_range(0, 1);
        ls_be    = BW'($urandom);
        ls_addr  = $urandom;
        ls_wdata = $urandom;
      end
      #4;
      model_eval();
      chk("rnd mem_req", 64'(mem_req), 64'(e_mreq));
      chk("rnd if_gnt", 64'(if_gnt), 64'(e_ifg));
      chk("rnd ls_gnt", 64'(ls_gnt), 64'(e_lsg));
      chk("rnd if_rvalid", 64'(if_rvalid), 64'(e_ifr));
      chk("rnd ls_rvalid", 64'(ls_rvalid), 64'(e_lsr));
      chk("rnd if_rdata", 64'(if_rdata), e_ifr ? 64'(mem_rdata) : 64'd0);
      chk("rnd ls_rdata", 64'(ls_rdata), e_lsr ? 64'(mem_rdata) : 64'd0);
      if (c > 0) chk("rnd sel", 64'(sel), 64'(m_sel));
      if (e_mreq) chk_mem_fields("rnd", m_sel);
      ig = e_ifg;
      lg = e_lsg;
      model_step();
      @(posedge clk); #1;
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/core_mem_arbiter.md
Name: core_mem_arbiter

Overview:
- Shares the core's single memory port between two requesters: instruction fetch (IF, port A) and load/store unit (LS, port B).
- Latches one owner and drives the owner code onto `sel` so the address and write-data 2:1 muxes steer the correct requester.
- Sequences exactly one outstanding transaction: request, grant, then response.
- Returns the response to the owner only.

Parameters:
- ADDR_WIDTH, 32, address width of both requesters and the memory port.
- DATA_WIDTH, 32, data width; byte-enable width is DATA_WIDTH/8.

Ports:
- clk  in  1  core clock
- rst  in  1  synchronous, active-high reset
- if_req  in  1  fetch request; held with if_addr until if_gnt
- if_addr  in  ADDR_WIDTH  fetch address
- if_gnt  out  1  one-cycle pulse: fetch request accepted by memory
- if_rvalid  out  1  one-cycle pulse: fetch data valid
- if_rdata  out  DATA_WIDTH  fetch read data
- ls_req  in  1  load/store request; held with its fields until ls_gnt
- ls_we  in  1  1 = store
- ls_be  in  DATA_WIDTH/8  byte enables
- ls_addr  in  ADDR_WIDTH  data address
- ls_wdata  in  DATA_WIDTH  store data
- ls_gnt  out  1  one-cycle pulse: data request accepted
- ls_rvalid  out  1  one-cycle pulse: load data / store ack valid
- ls_rdata  out  DATA_WIDTH  load read data
- mem_req  out  1  memory request
- mem_we  out  1  write enable (0 when owner is IF)
- mem_be  out  DATA_WIDTH/8  byte enables (all ones when owner is IF)
- mem_addr  out  ADDR_WIDTH  muxed address
- mem_wdata  out  DATA_WIDTH  muxed write data (0 when owner is IF)
- mem_gnt  in  1  memory accepts the request this cycle
- mem_rvalid  in  1  memory response valid (reads and writes)
- mem_rdata  in  DATA_WIDTH  memory read data
- sel  out  1  current owner: 0 = IF, 1 = LS

Behaviour:
- States: IDLE, REQ, WAIT.
- Reset (synchronous, any state): state = IDLE, owner = 0. Reset values of outputs:
  - sel = 0
  - mem_req = 0
  - all gnt/rvalid outputs = 0
  - rdata outputs pass mem_rdata but are qualified by rvalid.
- Any in-flight transaction is abandoned on reset; a late mem_rvalid after reset is ignored.
- IDLE:
  - No request: stay in IDLE.
  - Any request: latch the winner into owner and go to REQ next cycle.
  - Fixed priority: LS beats IF when both requests are high in the same cycle.
- REQ:
  - mem_req = 1; mem_* fields are driven combinationally from the owner's inputs via `sel`.
  - Owner is locked; requests from the other port are ignored.
  - mem_gnt = 1: pulse the owner's gnt in the same cycle and go to WAIT.
  - Otherwise stay in REQ with mem_req still asserted (no retraction).
- WAIT:
  - mem_req = 0.
  - mem_rvalid = 1: pulse the owner's rvalid in the same cycle, forward mem_rdata, go to IDLE.
  - A new request is therefore arbitrated the following cycle; IF-to-IF back-to-back takes 3 cycles minimum.
- mem_rvalid in IDLE or REQ: ignored, no rvalid output.
- The non-owner's gnt and rvalid are never asserted.
- Latency, with zero-wait memory: req high at cycle 0 → mem_req at cycle 1 → gnt at cycle 1 → rvalid at cycle 2 at the earliest.
- Simultaneous events:
  - mem_rvalid together with new requests in WAIT: response is completed, then arbitration happens in IDLE next cycle.
  - mem_gnt together with mem_rvalid in REQ: the rvalid is ignored (memory protocol forbids this).

Optional Feature:
- Macro: ARB_ROUND_ROBIN_EN.
- Defined:
  - A last-owner flop (reset 0) records the most recent granted owner.
  - On a tie in IDLE, the port that was not the last owner wins.
  - No starvation: each port waits at most one transaction.
- Undefined: fixed priority, LS over IF; no last-owner flop.

Decomposition:
- defines.vh:
  - state encodings `ARB_IDLE` 2'b00, `ARB_REQ` 2'b01, `ARB_WAIT` 2'b10
  - owner codes `OWN_IF` 1'b0, `OWN_LS` 1'b1
- Sub-module: the existing multiplexer2, instantiated twice (address, write data) with select = sel.
- Arbitration, FSM and response routing stay in this module.

Test Plan:
- Reset held 2 cycles while if_req=1 → mem_req=0, sel=0, no gnt; release → mem_req=1 the next cycle with mem_addr=if_addr.
- if_req with if_addr=0x0000_0040, mem_gnt immediate, mem_rvalid one cycle later with rdata=0x0013_0093 → if_gnt pulse 1 cycle, if_rvalid pulse with if_rdata=0x0013_0093, ls_* outputs stay 0.
- if_req and ls_req raised in the same cycle (ls_we=1, ls_addr=0x100, ls_wdata=0xDEADBEEF, ls_be=4'b0011) → LS served first with sel=1 and mem fields equal to the LS values; IF served after LS rvalid.
- mem_gnt held low 5 cycles in REQ while the other port toggles its request → mem_req held, owner unchanged, mem_addr stable.
- Reset asserted in WAIT, then mem_rvalid arrives → no rvalid on either port, FSM in IDLE.
- With ARB_ROUND_ROBIN_EN defined, both ports continuously requesting → grants alternate LS, IF, LS, IF; without the macro → LS only.
